// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8-bit UART receiver, start + 8 data (MSB first) + parity + stop, 27 clocks per bit
//
// Ports:
//   clk_3125    in   3.125 MHz clock, all logic on rising edge
//   rst_n       in   asynchronous active-low reset
//   rx          in   serial line, idle high, asynchronous to clk_3125
//   parity_type in   0 = even, 1 = odd; sampled at the parity bit midpoint
//   rx_msg      out  last accepted byte, first serial data bit in bit 7
//   rx_parity   out  parity bit received with rx_msg
//   parity_err  out  received parity did not match parity_type
//   rx_complete out  one-cycle pulse when a frame is accepted
//
// Build option: define UART_RX_PARITY_CHECK_EN to enable the parity comparison;
// without it parity_err is tied to 0 while rx_parity is still captured.

module uart_rx (
    input  logic       clk_3125,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       parity_type,
    output logic [7:0] rx_msg,
    output logic       rx_parity,
    output logic       parity_err,
    output logic       rx_complete
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [4:0] CNT_MID  = 5'd13;
    localparam logic [4:0] CNT_LAST = 5'd26;

    state_t     state, state_n;
    logic [4:0] cnt, cnt_n;
    logic [2:0] idx, idx_n;
    logic [7:0] shreg, shreg_n;
    logic       par_bit, par_bit_n;
    logic       stop_bad, stop_bad_n;   // stop bit sampled low; waiting for line to return high
    logic [7:0] msg_n;
    logic       rx_par_n;
    logic       done_n;

    logic       rx_sync1;
    logic       rxs;
    logic       mid;
    logic       last;

    assign mid  = (cnt == CNT_MID);
    assign last = (cnt == CNT_LAST);

    // Two-flop synchronizer; flops reset to the idle level so reset never looks like a start bit.
    always_ff @(posedge clk_3125 or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync1 <= 1'b1;
            rxs      <= 1'b1;
        end else begin
            rx_sync1 <= rx;
            rxs      <= rx_sync1;
        end
    end

    always_ff @(posedge clk_3125 or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 5'd0;
            idx         <= 3'd0;
            shreg       <= 8'h00;
            par_bit     <= 1'b0;
            stop_bad    <= 1'b0;
            rx_msg      <= 8'h00;
            rx_parity   <= 1'b0;
            rx_complete <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            idx         <= idx_n;
            shreg       <= shreg_n;
            par_bit     <= par_bit_n;
            stop_bad    <= stop_bad_n;
            rx_msg      <= msg_n;
            rx_parity   <= rx_par_n;
            rx_complete <= done_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        idx_n      = idx;
        shreg_n    = shreg;
        par_bit_n  = par_bit;
        stop_bad_n = stop_bad;
        msg_n      = rx_msg;
        rx_par_n   = rx_parity;
        done_n     = 1'b0;

        if (state != IDLE) begin
            cnt_n = last ? 5'd0 : cnt + 5'd1;
        end

        case (state)
            IDLE: begin
                cnt_n      = 5'd0;
                idx_n      = 3'd0;
                stop_bad_n = 1'b0;
                if (!rxs) begin
                    state_n = START;
                end
            end
            START: begin
                if (mid && rxs) begin
                    // Line went back high before mid-bit: treat as noise.
                    state_n = IDLE;
                    cnt_n   = 5'd0;
                end else if (last) begin
                    state_n = DATA;
                end
            end
            DATA: begin
                if (mid) begin
                    shreg_n = {shreg[6:0], rxs};
                end
                if (last) begin
                    if (idx == 3'd7) begin
                        idx_n   = 3'd0;
                        state_n = PARITY;
                    end else begin
                        idx_n = idx + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (mid) begin
                    par_bit_n = rxs;
                end
                if (last) begin
                    state_n = STOP;
                end
            end
            STOP: begin
                if (stop_bad) begin
                    // Framing error: a line still held low must not be taken as a new start bit.
                    cnt_n = 5'd0;
                    if (rxs) begin
                        state_n = IDLE;
                    end
                end else if (mid) begin
                    if (rxs) begin
                        msg_n    = shreg;
                        rx_par_n = par_bit;
                        done_n   = 1'b1;
                        state_n  = IDLE;
                        cnt_n    = 5'd0;
                    end else begin
                        stop_bad_n = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = 5'd0;
            end
        endcase
    end

`ifdef UART_RX_PARITY_CHECK_EN
    // Mismatch is evaluated at the parity bit midpoint (the byte is complete by then)
    // and only published together with the accepted frame.
    logic perr_pending;

    always_ff @(posedge clk_3125 or negedge rst_n) begin
        if (!rst_n) begin
            perr_pending <= 1'b0;
            parity_err   <= 1'b0;
        end else begin
            if (state == PARITY && mid) begin
                perr_pending <= rxs ^ (parity_type ? ~^shreg : ^shreg);
            end
            if (done_n) begin
                parity_err <= perr_pending;
            end
        end
    end
`else
    logic unused_parity_type;
    assign unused_parity_type = parity_type;
    assign parity_err         = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx

`timescale 1ns/1ps

module tb_uart_rx;

    logic       clk_3125;
    logic       rst_n;
    logic       rx;
    logic       parity_type;
    logic [7:0] rx_msg;
    logic       rx_parity;
    logic       parity_err;
    logic       rx_complete;

    int errors = 0;
    int checks = 0;

    int         pulses = 0;
    logic [7:0] msg_q[$];

`ifdef UART_RX_PARITY_CHECK_EN
    localparam logic PERR_ON_BAD = 1'b1;
`else
    localparam logic PERR_ON_BAD = 1'b0;
`endif

    uart_rx dut (
        .clk_3125    (clk_3125),
        .rst_n       (rst_n),
        .rx          (rx),
        .parity_type (parity_type),
        .rx_msg      (rx_msg),
        .rx_parity   (rx_parity),
        .parity_err  (parity_err),
        .rx_complete (rx_complete)
    );

    initial clk_3125 = 1'b0;
    always #160 clk_3125 = ~clk_3125;

    always @(negedge clk_3125) begin
        if (rx_complete) begin
            pulses++;
            msg_q.push_back(rx_msg);
        end
    end

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk_3125);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (27) @(negedge clk_3125);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic p, input logic s);
        send_bit(1'b0);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        send_bit(p);
        send_bit(s);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        rx = 1'b1;
        parity_type = 1'b0;
        repeat (4) @(negedge clk_3125);
        checks++; if (rx_msg !== 8'h00) begin errors++; $display("FAIL reset_msg got=%h exp=00", rx_msg); end
        checks++; if (rx_parity !== 1'b0) begin errors++; $display("FAIL reset_par got=%b exp=0", rx_parity); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr got=%b exp=0", parity_err); end
        checks++; if (rx_complete !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", rx_complete); end
        rst_n = 1'b1;
        idle(5);
    endtask

    task automatic test_even_parity;
        int p0;
        p0 = pulses;
        parity_type = 1'b0;
        send_frame(8'hA5, 1'b0, 1'b1);
        idle(5);
        checks++; if (pulses - p0 !== 1) begin errors++; $display("FAIL even_pulses got=%0d exp=1", pulses - p0); end
        checks++; if (rx_msg !== 8'hA5) begin errors++; $display("FAIL even_msg got=%h exp=a5", rx_msg); end
        checks++; if (rx_parity !== 1'b0) begin errors++; $display("FAIL even_par got=%b exp=0", rx_parity); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL even_perr got=%b exp=0", parity_err); end
    endtask

    task automatic test_odd_parity_err;
        int p0;
        p0 = pulses;
        parity_type = 1'b1;
        send_frame(8'h3C, 1'b0, 1'b1);
        idle(5);
        checks++; if (pulses - p0 !== 1) begin errors++; $display("FAIL odd_pulses got=%0d exp=1", pulses - p0); end
        checks++; if (rx_msg !== 8'h3C) begin errors++; $display("FAIL odd_msg got=%h exp=3c", rx_msg); end
        checks++; if (rx_parity !== 1'b0) begin errors++; $display("FAIL odd_par got=%b exp=0", rx_parity); end
        checks++; if (parity_err !== PERR_ON_BAD) begin errors++; $display("FAIL odd_perr got=%b exp=%b", parity_err, PERR_ON_BAD); end
    endtask

    task automatic test_glitch;
        int p0;
        p0 = pulses;
        parity_type = 1'b0;
        rx = 1'b0;
        repeat (5) @(negedge clk_3125);
        idle(80);
        checks++; if (pulses !== p0) begin errors++; $display("FAIL glitch_pulses got=%0d exp=%0d", pulses, p0); end
        checks++; if (rx_msg !== 8'h3C) begin errors++; $display("FAIL glitch_msg got=%h exp=3c", rx_msg); end
        checks++; if (parity_err !== PERR_ON_BAD) begin errors++; $display("FAIL glitch_perr got=%b exp=%b", parity_err, PERR_ON_BAD); end
        send_frame(8'h01, 1'b1, 1'b1);
        idle(5);
        checks++; if (pulses - p0 !== 1) begin errors++; $display("FAIL after_glitch_pulses got=%0d exp=1", pulses - p0); end
        checks++; if (rx_msg !== 8'h01) begin errors++; $display("FAIL after_glitch_msg got=%h exp=01", rx_msg); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL after_glitch_perr got=%b exp=0", parity_err); end
        idle(100);
        checks++; if (rx_msg !== 8'h01) begin errors++; $display("FAIL hold_msg got=%h exp=01", rx_msg); end
    endtask

    task automatic test_framing_error;
        int p0;
        p0 = pulses;
        send_frame(8'hFF, 1'b0, 1'b0);
        repeat (40) @(negedge clk_3125);
        idle(320);
        checks++; if (pulses !== p0) begin errors++; $display("FAIL frame_err_pulses got=%0d exp=%0d", pulses, p0); end
        checks++; if (rx_msg !== 8'h01) begin errors++; $display("FAIL frame_err_msg got=%h exp=01", rx_msg); end
        send_frame(8'h55, 1'b0, 1'b1);
        idle(5);
        checks++; if (pulses - p0 !== 1) begin errors++; $display("FAIL after_frame_pulses got=%0d exp=1", pulses - p0); end
        checks++; if (rx_msg !== 8'h55) begin errors++; $display("FAIL after_frame_msg got=%h exp=55", rx_msg); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] bytes [10];
        logic [7:0] got;
        bytes = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h0F, 8'hE7};
        msg_q.delete();
        parity_type = 1'b0;
        for (int i = 0; i < 10; i++) begin
            send_frame(bytes[i], ^bytes[i], 1'b1);
            idle(1);
        end
        idle(5);
        checks++; if (msg_q.size() !== 10) begin errors++; $display("FAIL b2b_count got=%0d exp=10", msg_q.size()); end
        for (int i = 0; i < 10; i++) begin
            got = (i < msg_q.size()) ? msg_q[i] : 8'hxx;
            checks++; if (got !== bytes[i]) begin errors++; $display("FAIL b2b_msg[%0d] got=%h exp=%h", i, got, bytes[i]); end
        end
    endtask

    task automatic test_reset_mid_frame;
        int p0;
        logic [7:0] b;
        b = 8'hC3;
        p0 = pulses;
        send_bit(1'b0);
        for (int i = 7; i >= 4; i--) send_bit(b[i]);
        rx = b[3];
        repeat (10) @(negedge clk_3125);
        rst_n = 1'b0;
        #1;
        checks++; if (rx_msg !== 8'h00) begin errors++; $display("FAIL midrst_msg got=%h exp=00", rx_msg); end
        checks++; if (rx_parity !== 1'b0) begin errors++; $display("FAIL midrst_par got=%b exp=0", rx_parity); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL midrst_perr got=%b exp=0", parity_err); end
        checks++; if (rx_complete !== 1'b0) begin errors++; $display("FAIL midrst_done got=%b exp=0", rx_complete); end
        rx = 1'b1;
        repeat (3) @(negedge clk_3125);
        rst_n = 1'b1;
        idle(300);
        checks++; if (pulses !== p0) begin errors++; $display("FAIL midrst_pulses got=%0d exp=%0d", pulses, p0); end
        send_frame(8'h81, 1'b0, 1'b1);
        idle(5);
        checks++; if (pulses - p0 !== 1) begin errors++; $display("FAIL after_rst_pulses got=%0d exp=1", pulses - p0); end
        checks++; if (rx_msg !== 8'h81) begin errors++; $display("FAIL after_rst_msg got=%h exp=81", rx_msg); end
    endtask

    initial begin
        test_reset();
        test_even_parity();
        test_odd_parity_err();
        test_glitch();
        test_framing_error();
        test_back_to_back();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have ports: clk_3125  input  1  3.125 MHz system clock, all logic on rising edge.
REQ-002 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have port: rx  input  1  serial line, idle high, asynchronous to clk_3125.
REQ-004 SHALL have port: parity_type  input  1  0 = even parity, 1 = odd parity; sampled at parity-bit check.
REQ-005 SHALL have port: rx_msg  output  8  last received data byte, first serial data bit in bit 7.
REQ-006 SHALL have port: rx_parity  output  1  parity bit received with rx_msg.
REQ-007 SHALL have port: parity_err  output  1  1 = received parity mismatched parity_type.
REQ-008 SHALL have port: rx_complete  output  1  one-cycle pulse, frame accepted.

Function
REQ-009 SHALL accept 11-bit frames: start(0), 8 data bits MSB-first, parity, stop(1); 27 clk_3125 cycles per bit.
REQ-010 SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized value rxs.
REQ-011 SHALL implement states IDLE, START, DATA, PARITY, STOP, with a 5-bit cycle counter cnt (0..26) and a 3-bit data index.
REQ-012 IDLE: on rxs==0, SHALL go to START with cnt=0; otherwise remain in IDLE.
REQ-013 In every non-IDLE state, cnt SHALL increment each cycle and the line SHALL be sampled at cnt==13.
REQ-014 At cnt==26, cnt SHALL wrap to 0 and the next bit's state SHALL be entered.
REQ-015 START: sample 1 at cnt==13 SHALL be a glitch; return to IDLE next cycle with no output change.
REQ-016 DATA: sample k (k=0..7) SHALL shift into an internal byte so the first bit lands in bit 7; after 8 bits go to PARITY.
REQ-017 PARITY: the sample SHALL be held internally; after cnt==26 go to STOP.
REQ-018 STOP: sample 1 at cnt==13 SHALL, on the next cycle, load rx_msg and rx_parity, update parity_err, pulse rx_complete high for exactly one cycle, and return to IDLE.
REQ-019 STOP: sample 0 at cnt==13 SHALL be a framing error. The frame SHALL be discarded with no rx_complete and no output change. The block SHALL return to IDLE only after rxs==1 is seen.
REQ-020 Expected parity SHALL be ^byte for parity_type=0 and ~^byte for parity_type=1; parity_err = (received parity != expected).
REQ-021 A frame with a parity error SHALL still complete with rx_complete=1 and parity_err=1.
REQ-022 rx_msg, rx_parity and parity_err SHALL hold their values until the next rx_complete.
REQ-023 Back-to-back frames SHALL be received when the next start bit begins 1 or more cycles after the stop-bit midpoint.
REQ-024 rx activity during DATA/PARITY other than at cnt==13 SHALL be ignored (no resynchronization mid-frame).

Reset
REQ-025 rst_n low SHALL immediately force state=IDLE, cnt=0, index=0, synchronizer flops=1, rx_msg=8'h00, rx_parity=0, parity_err=0, rx_complete=0.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no rx_complete. After release, reception SHALL restart only on a new start bit.

Configuration
REQ-027 Macro UART_RX_PARITY_CHECK_EN defined: parity_err SHALL behave per REQ-020/021.
REQ-028 Macro UART_RX_PARITY_CHECK_EN undefined: parity_err SHALL be constant 0, with no parity comparison logic; rx_parity SHALL still be captured.

Verification
REQ-029 Even parity, byte 8'hA5 sent MSB-first with parity 0 -> one rx_complete pulse; rx_msg=8'hA5, rx_parity=0, parity_err=0.
REQ-030 Odd parity, byte 8'h3C sent with parity 0 (wrong) -> rx_complete=1, rx_msg=8'h3C, parity_err=1 (0 if macro undefined).
REQ-031 rx low pulse of 5 cycles in IDLE -> no rx_complete; outputs unchanged; next valid frame 8'h01 received correctly.
REQ-032 Frame 8'hFF with stop bit 0 -> no rx_complete; rx_msg keeps the prior value; after rx high, frame 8'h55 is received.
REQ-033 10 back-to-back frames from uart_tx (1-cycle gap, tx_start per frame) -> 10 rx_complete pulses, each rx_msg equal to the transmitted byte.
REQ-034 rst_n pulsed low during DATA bit 4 of 8'hC3 -> all outputs return to reset values at once; no rx_complete; next frame 8'h81 is received correctly.
